// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arbiter
//  Description : Round-robin arbiter owning the ALU operand mux select, with a
//                registered, valid-qualified copy of the selected operand.
//                Optional burst limit: define MUX_ARB_BURST_LIMIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_arbiter #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int SEL_LENGTH = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          req,
    input  logic [CHANNELS*WIDTH-1:0]    in_bus,
    output logic [CHANNELS-1:0]          grant,
    output logic [SEL_LENGTH-1:0]        sel,
    output logic [WIDTH-1:0]             out,
    output logic                         out_valid,
    output logic                         busy
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_OWN  = 1'b1;

    logic [0:0]            r_state;
    logic [SEL_LENGTH-1:0] r_ptr;
    logic [SEL_LENGTH-1:0] r_sel;
    logic [CHANNELS-1:0]   r_grant;
    logic [WIDTH-1:0]      r_out;
    logic                  r_out_valid;

    logic                  w_busy;
    logic                  w_owner_req;
    logic [WIDTH-1:0]      w_data;
    logic [SEL_LENGTH-1:0] w_owner_next;
    logic [SEL_LENGTH-1:0] w_start;
    logic                  w_found;
    logic [SEL_LENGTH-1:0] w_winner;
    logic [CHANNELS-1:0]   w_winner_oh;
    logic                  w_release;
    logic                  w_burst_force;

    // Configurations that cannot be honoured elaborate this empty marker block
    if (CHANNELS > (1 << SEL_LENGTH) || MAX_BURST < 1) begin : g_bad_config
    end

    assign w_busy = (r_state == c_ST_OWN);

    // Decoding against legal indices only keeps sel/data inside CHANNELS
    always_comb begin
        w_owner_req = 1'b0;
        w_data      = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (r_sel == SEL_LENGTH'(j)) begin
                w_owner_req = req[j];
                w_data      = in_bus[j*WIDTH +: WIDTH];
            end
        end
    end

    assign w_owner_next = (r_sel >= SEL_LENGTH'(CHANNELS-1)) ? '0 : r_sel + SEL_LENGTH'(1);
    assign w_start      = w_busy ? w_owner_next : r_ptr;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            for (int j = 0; j < CHANNELS; j++) begin
                if (!w_found && req[j] && (((int'(w_start) + k) % CHANNELS) == j)) begin
                    w_found  = 1'b1;
                    w_winner = SEL_LENGTH'(j);
                end
            end
        end
    end

    always_comb begin
        w_winner_oh = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            w_winner_oh[j] = (w_winner == SEL_LENGTH'(j));
        end
    end

    assign w_release = w_busy && (!w_owner_req || w_burst_force);

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam int c_CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_BURST - 1);

    logic [c_CNT_W-1:0] r_burst;
    logic               w_grant_new;

    assign w_grant_new   = w_found && (!w_busy || w_release);
    assign w_burst_force = (r_burst == c_CNT_LAST) && (|(req & ~r_grant));

    // Saturates at the limit so a lone owner keeps its grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_burst <= '0;
        end else if (w_grant_new) begin
            r_burst <= '0;
        end else if (w_busy && (r_burst != c_CNT_LAST)) begin
            r_burst <= r_burst + c_CNT_W'(1);
        end
    end
`else
    assign w_burst_force = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_grant     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out       <= w_data;
            r_out_valid <= w_busy;
            if (r_state == c_ST_IDLE) begin
                if (w_found) begin
                    r_state <= c_ST_OWN;
                    r_grant <= w_winner_oh;
                    r_sel   <= w_winner;
                end else begin
                    r_grant <= '0;
                end
            end else if (w_release) begin
                // Handover happens on the release edge itself: no gap, no overlap
                r_ptr <= w_owner_next;
                if (w_found) begin
                    r_grant <= w_winner_oh;
                    r_sel   <= w_winner;
                end else begin
                    r_state <= c_ST_IDLE;
                    r_grant <= '0;
                end
            end
        end
    end

    assign grant     = r_grant;
    assign sel       = r_sel;
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = w_busy;

endmodule
`default_nettype wire
